// File: rtl/branch_pkg.sv
// Shared branch/jump definitions: op encoding, branch condition codes and
// the link-register test used for return-address-stack hints.
package branch_pkg;

  typedef enum logic [1:0] {
    OP_BRANCH = 2'b00,
    OP_JAL    = 2'b01,
    OP_JALR   = 2'b10,
    OP_NONE   = 2'b11
  } op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // x1 (ra) and x5 (t0) are the conventional link registers.
  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

endpackage

// File: rtl/branch_target_unit_if.sv
// Request/result bundle of the branch target unit. The master drives requests
// and consumes results; the slave (the unit) does the opposite.
interface branch_target_unit_if
  import branch_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  op_e             op;
  logic [2:0]      funct3;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [4:0]      rd;
  logic [4:0]      rs1_addr;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] ras_pred;
  logic            taken;
  logic            misaligned;
  logic            ras_hit;

  modport master (
    output in_valid, op, funct3, pc, imm, rs1, rs2, rd, rs1_addr, flush, out_ready,
    input  in_ready, out_valid, target, link, ras_pred, taken, misaligned, ras_hit
  );

  modport slave (
    input  in_valid, op, funct3, pc, imm, rs1, rs2, rd, rs1_addr, flush, out_ready,
    output in_ready, out_valid, target, link, ras_pred, taken, misaligned, ras_hit
  );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack. ptr addresses the next free slot, so the top
// entry sits at ptr-1. Pushing when full overwrites the oldest entry (which is
// the slot at ptr); popping when empty is ignored. push together with pop on a
// non-empty stack replaces the top entry in place.
module return_addr_stack #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [PW:0]   CNT_ONE = 1;
  localparam logic [PW:0]   DEPTH_C = RAS_DEPTH[PW:0];

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   top_idx;
  logic [PW:0]     cnt;

  assign top_idx = ptr - PTR_ONE;
  assign top     = mem[top_idx];
  assign empty   = (cnt == '0);
  assign full    = (cnt == DEPTH_C);

  // Stack storage, pointer and occupancy update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (push && pop && !empty) begin
      mem[top_idx] <= din;
    end else if (push) begin
      mem[ptr] <= din;
      ptr      <= ptr + PTR_ONE;
      if (!full) cnt <= cnt + CNT_ONE;
    end else if (pop && !empty) begin
      ptr <= top_idx;
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_target_unit.sv
// Branch target unit: resolves branch/jump targets and direction, produces
// the link address and checks return predictions against a return-address
// stack. One registered stage with a ready/valid result handshake.
// Build option: define C_EXT_EN for 2-byte instruction alignment (compressed
// ISA); otherwise targets must be 4-byte aligned.
module branch_target_unit
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  branch_target_unit_if.slave bus
);

  function automatic logic branch_cond(input logic [2:0] f3,
                                       input logic [XLEN-1:0] a,
                                       input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    sa = a;
    sb = b;
    case (f3)
      F3_BEQ:  return a == b;
      F3_BNE:  return a != b;
      F3_BLT:  return sa < sb;
      F3_BGE:  return sa >= sb;
      F3_BLTU: return a < b;
      F3_BGEU: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic misalign(input logic tk, input logic [XLEN-1:0] t);
`ifdef C_EXT_EN
    return tk && t[0];
`else
    return tk && t[1];
`endif
  endfunction

  logic            accept;
  logic            taken_c;
  logic [XLEN-1:0] target_c;
  logic [XLEN-1:0] sum_pc;
  logic [XLEN-1:0] sum_rs;
  logic            push_c;
  logic            pop_c;
  logic            hit_c;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full_unused;

  logic            vld_p1;
  logic [XLEN-1:0] target_p1;
  logic [XLEN-1:0] link_p1;
  logic [XLEN-1:0] ras_pred_p1;
  logic            taken_p1;
  logic            misaligned_p1;
  logic            ras_hit_p1;

  assign bus.in_ready = !bus.flush && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Target and direction resolution for the presented request.
  always_comb begin
    sum_pc   = bus.pc + bus.imm;
    sum_rs   = bus.rs1 + bus.imm;
    target_c = sum_pc;
    taken_c  = 1'b0;
    case (bus.op)
      OP_BRANCH: taken_c = branch_cond(bus.funct3, bus.rs1, bus.rs2);
      OP_JAL:    taken_c = 1'b1;
      OP_JALR: begin
        taken_c  = 1'b1;
        target_c = sum_rs & ~XLEN'(1);
      end
      default:   taken_c = 1'b0;
    endcase
  end

  // Return-stack hints: calls push, returns pop, call-through-link replaces.
  always_comb begin
    push_c = accept && (bus.op == OP_JAL || bus.op == OP_JALR) && is_link(bus.rd);
    pop_c  = accept && (bus.op == OP_JALR) && is_link(bus.rs1_addr) &&
             !(is_link(bus.rd) && (bus.rd == bus.rs1_addr));
    hit_c  = pop_c && !ras_empty && (ras_top == target_c);
  end

  return_addr_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (bus.pc + XLEN'(4)),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full_unused)
  );

  // ---- stage p1: registered result, held while the consumer stalls ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1        <= 1'b0;
      target_p1     <= '0;
      link_p1       <= '0;
      ras_pred_p1   <= '0;
      taken_p1      <= 1'b0;
      misaligned_p1 <= 1'b0;
      ras_hit_p1    <= 1'b0;
    end else if (bus.flush) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1        <= 1'b1;
      target_p1     <= target_c;
      link_p1       <= bus.pc + XLEN'(4);
      ras_pred_p1   <= ras_top;
      taken_p1      <= taken_c;
      misaligned_p1 <= misalign(taken_c, target_c);
      ras_hit_p1    <= hit_c;
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.out_valid  = vld_p1;
  assign bus.target     = target_p1;
  assign bus.link       = link_p1;
  assign bus.ras_pred   = ras_pred_p1;
  assign bus.taken      = taken_p1;
  assign bus.misaligned = misaligned_p1;
  assign bus.ras_hit    = ras_hit_p1;

endmodule

// File: tb/tb_branch_target_unit.sv
// Scoreboard bench for branch_target_unit: a reference model computes the
// expected result (including a queue-based return stack) at acceptance time,
// and a monitor compares each handed-off result in order.
module tb_branch_target_unit;
  import branch_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] target;
    logic [31:0] link;
    logic [31:0] pred;
    logic        taken;
    logic        mis;
    logic        hit;
    logic        chk_pred;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_target_unit_if #(.XLEN(XLEN)) bus ();

  branch_target_unit #(.XLEN(XLEN), .RAS_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t        sb[$];
  logic [31:0] mstk[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic lnk(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // Reference model: expected result plus return-stack update.
  task automatic model(input op_e op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [4:0] rsa);
    exp_t e;
    logic [31:0] t;
    logic tk, psh, pp;
    t  = (op == OP_JALR) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    tk = 1'b0;
    case (op)
      OP_JAL, OP_JALR: tk = 1'b1;
      OP_BRANCH:
        case (f3)
          3'b000: tk = (a == b);
          3'b001: tk = (a != b);
          3'b100: tk = ($signed(a) <  $signed(b));
          3'b101: tk = ($signed(a) >= $signed(b));
          3'b110: tk = (a <  b);
          3'b111: tk = (a >= b);
          default: tk = 1'b0;
        endcase
      default: tk = 1'b0;
    endcase
    psh = (op == OP_JAL || op == OP_JALR) && lnk(rd);
    pp  = (op == OP_JALR) && lnk(rsa) && !(lnk(rd) && rd == rsa);
    e.target = t;
    e.link   = pc + 32'd4;
    e.taken  = tk;
`ifdef C_EXT_EN
    e.mis = tk && t[0];
`else
    e.mis = tk && t[1];
`endif
    e.chk_pred = (mstk.size() != 0);
    e.pred     = (mstk.size() != 0) ? mstk[$] : 32'h0;
    e.hit      = pp && (mstk.size() != 0) && (mstk[$] == t);
    if (pp && mstk.size() != 0) void'(mstk.pop_back());
    if (psh) begin
      mstk.push_back(pc + 32'd4);
      if (mstk.size() > DEPTH) void'(mstk.pop_front());
    end
    sb.push_back(e);
  endtask

  task automatic send(input op_e op, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [4:0] rsa);
    int n;
    bus.op = op; bus.funct3 = f3; bus.pc = pc; bus.imm = imm;
    bus.rs1 = a; bus.rs2 = b; bus.rd = rd; bus.rs1_addr = rsa;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) check_val("accept_timeout", 32'(bus.in_ready), 32'd1);
    else model(op, f3, pc, imm, a, b, rd, rsa);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    check_val("drain", 32'(sb.size()), 32'd0);
  endtask

  // Monitor: a transfer happens at the next rising edge when both are high.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check_val("unexpected_out", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("target", bus.target, e.target);
        check_val("link", bus.link, e.link);
        check_val("taken", 32'(bus.taken), 32'(e.taken));
        check_val("misaligned", 32'(bus.misaligned), 32'(e.mis));
        check_val("ras_hit", 32'(bus.ras_hit), 32'(e.hit));
        if (e.chk_pred) check_val("ras_pred", bus.ras_pred, e.pred);
      end
    end
  end

  initial begin
    logic [4:0] regs [4];
    regs[0] = 5'd0; regs[1] = 5'd1; regs[2] = 5'd5; regs[3] = 5'd2;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.op = OP_NONE; bus.funct3 = 3'b000;
    bus.pc = '0; bus.imm = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.rd = '0; bus.rs1_addr = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;

    #12;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_target", bus.target, 32'd0);
    check_val("rst_link", bus.link, 32'd0);
    check_val("rst_ras_pred", bus.ras_pred, 32'd0);
    check_val("rst_taken", 32'(bus.taken), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Branch conditions
    send(OP_BRANCH, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, 5'd0, 5'd0);
    send(OP_BRANCH, 3'b100, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0);
    send(OP_BRANCH, 3'b110, 32'h100, 32'h20, 32'hFFFF_FFFF, 32'd1, 5'd0, 5'd0);
    send(OP_BRANCH, 3'b001, 32'h104, 32'hFFFF_FFF0, 32'd3, 32'd4, 5'd0, 5'd0);
    send(OP_BRANCH, 3'b101, 32'h108, 32'h6, 32'h8000_0000, 32'd0, 5'd0, 5'd0);
    send(OP_BRANCH, 3'b111, 32'h10C, 32'h8, 32'h8000_0000, 32'd0, 5'd0, 5'd0);
    send(OP_BRANCH, 3'b010, 32'h110, 32'h8, 32'd1, 32'd1, 5'd0, 5'd0);
    send(OP_BRANCH, 3'b011, 32'hFFFF_FFF0, 32'h20, 32'd1, 32'd1, 5'd0, 5'd0);
    // JALR alignment
    send(OP_JALR, 3'b000, 32'h300, 32'h0, 32'h203, 32'h0, 5'd0, 5'd2);
    // Call then matching return
    send(OP_JAL, 3'b000, 32'h40, 32'h100, 32'h0, 32'h0, 5'd1, 5'd0);
    send(OP_JALR, 3'b000, 32'h200, 32'h0, 32'h44, 32'h0, 5'd0, 5'd1);
    // Overflow: nine calls then nine returns
    for (int i = 0; i < 9; i++)
      send(OP_JAL, 3'b000, 32'(4 * i), 32'h80, 32'h0, 32'h0, 5'd1, 5'd0);
    for (int i = 0; i < 9; i++)
      send(OP_JALR, 3'b000, 32'h400, 32'h0, 32'h24 - 32'(4 * i), 32'h0, 5'd0, 5'd1);
    // Replace-top and push-only JALR forms
    send(OP_JAL, 3'b000, 32'h500, 32'h40, 32'h0, 32'h0, 5'd1, 5'd0);
    send(OP_JALR, 3'b000, 32'h600, 32'h0, 32'h504, 32'h0, 5'd5, 5'd1);
    send(OP_JALR, 3'b000, 32'h620, 32'h4, 32'h700, 32'h0, 5'd1, 5'd1);
    send(OP_JALR, 3'b000, 32'h640, 32'h0, 32'h624, 32'h0, 5'd0, 5'd1);
    send(OP_JALR, 3'b000, 32'h660, 32'h0, 32'h604, 32'h0, 5'd0, 5'd5);
    send(OP_NONE, 3'b000, 32'h680, 32'h10, 32'h0, 32'h0, 5'd1, 5'd1);
    // Random mix
    for (int i = 0; i < 30; i++)
      send(op_e'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom & 32'hFFFC,
           32'($urandom_range(0, 15)), $urandom, $urandom,
           regs[$urandom_range(0, 3)], regs[$urandom_range(0, 3)]);
    drain();

    // Back-pressure: result and readiness hold while the consumer stalls
    bus.out_ready = 1'b0;
    send(OP_JAL, 3'b000, 32'h700, 32'h10, 32'h0, 32'h0, 5'd1, 5'd0);
    repeat (3) @(posedge clk);
    #1;
    check_val("stall_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("stall_out_valid", 32'(bus.out_valid), 32'd1);
    check_val("stall_target", bus.target, 32'h710);
    check_val("stall_link", bus.link, 32'h704);
    bus.out_ready = 1'b1;
    drain();

    // Flush drops a pending result but keeps the stack update
    bus.out_ready = 1'b0;
    send(OP_JAL, 3'b000, 32'h800, 32'h8, 32'h0, 32'h0, 5'd1, 5'd0);
    bus.flush = 1'b1;
    void'(sb.pop_front());
    #1;
    check_val("flush_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check_val("flush_out_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    send(OP_JALR, 3'b000, 32'h900, 32'h0, 32'h804, 32'h0, 5'd0, 5'd1);
    drain();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++)
      send(OP_JAL, 3'b000, 32'hA00 + 32'(4 * i), 32'h10, 32'h0, 32'h0, 5'd1, 5'd0);
    drain();
    bus.out_ready = 1'b0;
    send(OP_NONE, 3'b000, 32'hB00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    check_val("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("async_rst_target", bus.target, 32'd0);
    check_val("async_rst_link", bus.link, 32'd0);
    sb.delete();
    mstk.delete();
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(OP_JALR, 3'b000, 32'hC00, 32'h0, 32'hA0C, 32'h0, 5'd0, 5'd1);
    #1;
    check_val("post_rst_ras_hit", 32'(bus.ras_hit), 32'd0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
